max_pool_stream: RTL and testbench

- Parametrised successor to the 4-input two-stage max unit in the CNN pooling datapath.
- Reduces NUM_IN packed lanes per beat through a registered comparator tree.
- Optionally reduces across ACC_LEN consecutive valid beats, so pooling windows larger than the lane count are supported.
- Emits the window maximum and its argmax index; the classifier head uses the index for top-1 selection.

---
 rtl/max_pool_stream.sv | 152 +++++++++++++++
 tb/tb_max_pool_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming max/argmax reducer.
// NUM_IN lanes per beat pass through a registered pairwise comparator tree,
// then an accumulator stage reduces ACC_LEN consecutive valid beats into one
// window maximum plus its flat argmax (beat*NUM_IN + lane).
module max_pool_stream #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_IN      = 4,
    parameter  int ACC_LEN     = 1,
    parameter  int SIGNED_MODE = 0,
    localparam int TREE_STAGES = (NUM_IN > 1) ? $clog2(NUM_IN) : 0,
    localparam int IDX_W       = (NUM_IN * ACC_LEN > 1) ? $clog2(NUM_IN * ACC_LEN) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]        max_data,
    output logic [IDX_W-1:0]             max_index,
    output logic                         valid_out,
    output logic                         busy
);

    localparam int LANE_W = (TREE_STAGES > 0) ? TREE_STAGES : 1;
    localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    // Strict greater-than; ties therefore keep the lower index / earlier beat.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        if (SIGNED_MODE != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic [DATA_WIDTH-1:0] tree_data;
    logic [LANE_W-1:0]     tree_lane;
    logic                  tree_valid;
    logic [LANE_W-1:0]     stage_v;

    generate
        if (TREE_STAGES == 0) begin : g_notree
            assign tree_data  = data_in[DATA_WIDTH-1:0];
            assign tree_lane  = '0;
            assign tree_valid = valid_in;
            assign stage_v    = '0;
        end else begin : g_tree
            for (genvar k = 0; k < TREE_STAGES; k++) begin : lvl
                localparam int N = NUM_IN >> (k + 1);

                logic [DATA_WIDTH-1:0] src_d  [2*N];
                logic [LANE_W-1:0]     src_ix [2*N];
                logic                  src_v;
                logic [DATA_WIDTH-1:0] d      [N];
                logic [LANE_W-1:0]     ix     [N];
                logic                  v;

                if (k == 0) begin : g_src
                    // Level 0 source: unpack the input lanes and tag each with its lane number.
                    always_comb begin
                        for (int unsigned j = 0; j < 2 * N; j++) begin
                            src_d[j]  = data_in[j*DATA_WIDTH +: DATA_WIDTH];
                            src_ix[j] = LANE_W'(j);
                        end
                        src_v = valid_in;
                    end
                end else begin : g_src
                    // Deeper levels read the previous level's registers.
                    always_comb begin
                        src_d  = lvl[k-1].d;
                        src_ix = lvl[k-1].ix;
                        src_v  = lvl[k-1].v;
                    end
                end

                // Register the winner of each adjacent pair; data holds when no beat arrives.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        v <= 1'b0;
                        for (int unsigned j = 0; j < N; j++) begin
                            d[j]  <= '0;
                            ix[j] <= '0;
                        end
                    end else begin
                        v <= src_v;
                        if (src_v) begin
                            for (int unsigned j = 0; j < N; j++) begin
                                if (gt(src_d[2*j+1], src_d[2*j])) begin
                                    d[j]  <= src_d[2*j+1];
                                    ix[j] <= src_ix[2*j+1];
                                end else begin
                                    d[j]  <= src_d[2*j];
                                    ix[j] <= src_ix[2*j];
                                end
                            end
                        end
                    end
                end

                assign stage_v[k] = v;
            end

            assign tree_data  = lvl[TREE_STAGES-1].d[0];
            assign tree_lane  = lvl[TREE_STAGES-1].ix[0];
            assign tree_valid = lvl[TREE_STAGES-1].v;
        end
    endgenerate

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] next_data;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      beat_idx;

    // Candidate window state: first beat loads, later beats replace only if strictly greater.
    always_comb begin
        beat_idx  = IDX_W'(int'(cnt) * NUM_IN + int'(tree_lane));
        next_data = acc_data;
        next_idx  = acc_idx;
        if (cnt == '0 || gt(tree_data, acc_data)) begin
            next_data = tree_data;
            next_idx  = beat_idx;
        end
    end

    // Beat counter and accumulator; the last beat of a window publishes the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_data  <= '0;
            acc_idx   <= '0;
            max_data  <= '0;
            max_index <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (tree_valid) begin
                if (cnt == CNT_W'(ACC_LEN - 1)) begin
                    max_data  <= next_data;
                    max_index <= next_idx;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc_data <= next_data;
                    acc_idx  <= next_idx;
                    cnt      <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (|stage_v) || (cnt != '0);

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: several parameterisations share the
// clock, reset and lane data; each has its own valid input.
module tb_max_pool_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0, vd = 1'b0, ve = 1'b0;

    logic [7:0] a_data, b_data, c_data, d_data, e_data;
    logic [1:0] a_idx, c_idx;
    logic [3:0] b_idx;
    logic [2:0] d_idx;
    logic [0:0] e_idx;
    logic       a_vo, b_vo, c_vo, d_vo, e_vo;
    logic       a_busy, b_busy, c_busy, d_busy, e_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 4 lanes, single-beat windows, unsigned
    max_pool_stream #(.DATA_WIDTH(8), .NUM_IN(4), .ACC_LEN(1), .SIGNED_MODE(0)) u_a (
        .clk(clk), .reset(reset), .valid_in(va), .data_in(data_in),
        .max_data(a_data), .max_index(a_idx), .valid_out(a_vo), .busy(a_busy));
    // 4 lanes, 3-beat windows, unsigned
    max_pool_stream #(.DATA_WIDTH(8), .NUM_IN(4), .ACC_LEN(3), .SIGNED_MODE(0)) u_b (
        .clk(clk), .reset(reset), .valid_in(vb), .data_in(data_in),
        .max_data(b_data), .max_index(b_idx), .valid_out(b_vo), .busy(b_busy));
    // 4 lanes, single-beat windows, signed
    max_pool_stream #(.DATA_WIDTH(8), .NUM_IN(4), .ACC_LEN(1), .SIGNED_MODE(1)) u_c (
        .clk(clk), .reset(reset), .valid_in(vc), .data_in(data_in),
        .max_data(c_data), .max_index(c_idx), .valid_out(c_vo), .busy(c_busy));
    // 4 lanes, 2-beat windows, unsigned
    max_pool_stream #(.DATA_WIDTH(8), .NUM_IN(4), .ACC_LEN(2), .SIGNED_MODE(0)) u_d (
        .clk(clk), .reset(reset), .valid_in(vd), .data_in(data_in),
        .max_data(d_data), .max_index(d_idx), .valid_out(d_vo), .busy(d_busy));
    // 1 lane, no tree
    max_pool_stream #(.DATA_WIDTH(8), .NUM_IN(1), .ACC_LEN(1), .SIGNED_MODE(0)) u_e (
        .clk(clk), .reset(reset), .valid_in(ve), .data_in(data_in[7:0]),
        .max_data(e_data), .max_index(e_idx), .valid_out(e_vo), .busy(e_busy));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] win [3];
    int          pulses;
    logic [7:0]  cap_data;
    logic [3:0]  cap_idx;

    task automatic sample_b();
        if (b_vo === 1'b1) begin
            pulses++;
            cap_data = b_data;
            cap_idx  = b_idx;
        end
    endtask

    initial begin
        win[0] = 32'h04030201;
        win[1] = 32'h00000008;
        win[2] = 32'h05050505;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_a_data", 32'(a_data), 0);
        chk("rst_a_idx",  32'(a_idx), 0);
        chk("rst_a_vo",   32'(a_vo), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_b_busy", 32'(b_busy), 0);

        // Single beat {3,9,7,1}; NUM_IN=1 instance sees lane 0 only
        data_in = 32'h01070903; va = 1'b1; ve = 1'b1;
        tick();
        va = 1'b0; ve = 1'b0;
        chk("e_vo_lat1", 32'(e_vo), 1);
        chk("e_data",    32'(e_data), 3);
        chk("e_idx",     32'(e_idx), 0);
        chk("a_vo_c1",   32'(a_vo), 0);
        chk("a_busy_c1", 32'(a_busy), 1);
        tick();
        chk("a_vo_c2", 32'(a_vo), 0);
        chk("e_vo_c2", 32'(e_vo), 0);
        tick();
        chk("a_vo_c3", 32'(a_vo), 1);
        chk("a_data",  32'(a_data), 9);
        chk("a_idx",   32'(a_idx), 1);
        tick();
        chk("a_vo_c4",     32'(a_vo), 0);
        chk("a_data_hold", 32'(a_data), 9);
        chk("a_idx_hold",  32'(a_idx), 1);

        // Three-beat window, back-to-back
        for (int b = 0; b < 3; b++) begin
            data_in = win[b]; vb = 1'b1;
            tick();
            chk("b2b_vo_early", 32'(b_vo), 0);
        end
        vb = 1'b0;
        tick();
        chk("b2b_vo_c4", 32'(b_vo), 0);
        tick();
        chk("b2b_vo",   32'(b_vo), 1);
        chk("b2b_data", 32'(b_data), 8);
        chk("b2b_idx",  32'(b_idx), 4);
        tick();
        chk("b2b_vo_off", 32'(b_vo), 0);
        chk("b2b_busy0",  32'(b_busy), 0);

        // Same window with two idle cycles after each beat
        for (int b = 0; b < 3; b++) begin
            data_in = win[b]; vb = 1'b1;
            tick();
            vb = 1'b0;
            for (int g = 0; g < 2; g++) begin
                chk("gap_busy", 32'(b_busy), 1);
                chk("gap_vo",   32'(b_vo), 0);
                tick();
            end
        end
        chk("gap_vo_out", 32'(b_vo), 1);
        chk("gap_data",   32'(b_data), 8);
        chk("gap_idx",    32'(b_idx), 4);
        tick();
        chk("gap_busy_end", 32'(b_busy), 0);

        // Signed vs unsigned compare
        data_in = 32'h90FFF080; va = 1'b1; vc = 1'b1;
        tick();
        data_in = 32'h30201080;
        tick();
        va = 1'b0; vc = 1'b0;
        tick();
        chk("s_neg_vo",   32'(c_vo), 1);
        chk("s_neg_data", 32'(c_data), 32'hFF);
        chk("s_neg_idx",  32'(c_idx), 2);
        chk("u_neg_data", 32'(a_data), 32'hFF);
        chk("u_neg_idx",  32'(a_idx), 2);
        tick();
        chk("s_mix_vo",   32'(c_vo), 1);
        chk("s_mix_data", 32'(c_data), 32'h30);
        chk("s_mix_idx",  32'(c_idx), 3);
        chk("u_mix_vo",   32'(a_vo), 1);
        chk("u_mix_data", 32'(a_data), 32'h80);
        chk("u_mix_idx",  32'(a_idx), 0);

        // Ties within and across beats
        data_in = 32'h06020606; vd = 1'b1;
        tick();
        data_in = 32'h01010106;
        tick();
        vd = 1'b0;
        tick();
        chk("tie_vo_early", 32'(d_vo), 0);
        tick();
        chk("tie_vo",   32'(d_vo), 1);
        chk("tie_data", 32'(d_data), 6);
        chk("tie_idx",  32'(d_idx), 0);

        // Reset mid-window discards partial window and in-flight beats
        data_in = 32'h09090909; vb = 1'b1;
        tick();
        tick();
        vb = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_data", 32'(b_data), 0);
        chk("mid_rst_idx",  32'(b_idx), 0);
        chk("mid_rst_vo",   32'(b_vo), 0);
        chk("mid_rst_busy", 32'(b_busy), 0);
        pulses = 0; cap_data = '0; cap_idx = '0;
        data_in = 32'h01010101; vb = 1'b1;
        tick(); sample_b();
        data_in = 32'h02020202;
        tick(); sample_b();
        data_in = 32'h00000000;
        tick(); sample_b();
        vb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); sample_b();
        end
        chk("mid_pulses", 32'(pulses), 1);
        chk("mid_data",   32'(cap_data), 2);
        chk("mid_idx",    32'(cap_idx), 4);

        chk("idle_busy_c", 32'(c_busy), 0);
        chk("idle_busy_d", 32'(d_busy), 0);
        chk("idle_busy_e", 32'(e_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
